// File: rtl/cmlk_dual_axis_frame_src.sv
// cmlk_dual_axis_frame_src: two FIFO-buffered sample sources framed into lock-stepped AXI4-Stream masters.
// Define CMLK_TX_PAD_EN to zero-pad an incomplete frame while draining.
module cmlk_dual_axis_frame_src #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [15:0]       frame_len,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_vld,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_vld,
    output logic [DATA_W-1:0] m00_axis_tdata,
    output logic              m00_axis_tvalid,
    output logic              m00_axis_tlast,
    input  logic              m00_axis_tready,
    output logic [DATA_W-1:0] m01_axis_tdata,
    output logic              m01_axis_tvalid,
    output logic              m01_axis_tlast,
    input  logic              m01_axis_tready,
    output logic              ovf_a,
    output logic              ovf_b,
    output logic [15:0]       frame_cnt,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int DEPTH = 2 ** FIFO_AW;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [FIFO_AW:0]  wa, ra, wb, rb;
    logic [DATA_W-1:0] da, db;
    logic              vld;
    logic [15:0]       beat, len;
    logic              active, empty_a, empty_b, full_a, full_b;
    logic              hs, last, bound, flush, pop, pad, wr_a, wr_b, start;

    always_comb begin
        active   = state != IDLE;
        start    = state == IDLE && enable;
        empty_a  = wa == ra;
        empty_b  = wb == rb;
        full_a   = wa == {~ra[FIFO_AW], ra[FIFO_AW-1:0]};
        full_b   = wb == {~rb[FIFO_AW], rb[FIFO_AW-1:0]};
        last     = vld && beat == len - 16'd1;
        hs       = vld && m00_axis_tready && m01_axis_tready;
        bound    = beat == 16'd0 && !vld;
        state_nx = state == IDLE ? (enable ? RUN : IDLE) :
                   state == RUN  ? (enable ? RUN : DRAIN) :
                   ((hs && last) || bound) ? IDLE : DRAIN;
        flush    = state == DRAIN && state_nx == IDLE;
        // both channels pop together so they can never slip
        pop      = active && !flush && !empty_a && !empty_b && (!vld || hs);
`ifdef CMLK_TX_PAD_EN
        pad      = state == DRAIN && !flush && !vld && (empty_a || empty_b);
`else
        pad      = 1'b0;
`endif
        wr_a     = active && a_vld && (!full_a || pop);
        wr_b     = active && b_vld && (!full_b || pop);
    end

    always_ff @(posedge clk) begin
        if (wr_a) mem_a[wa[FIFO_AW-1:0]] <= a_data;
        if (wr_b) mem_b[wb[FIFO_AW-1:0]] <= b_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wa        <= '0;
            ra        <= '0;
            wb        <= '0;
            rb        <= '0;
            vld       <= 1'b0;
            da        <= '0;
            db        <= '0;
            beat      <= 16'd0;
            len       <= 16'd1;
            frame_cnt <= 16'd0;
            ovf_a     <= 1'b0;
            ovf_b     <= 1'b0;
        end else begin
            state <= state_nx;
            wa    <= flush ? '0 : wa + (FIFO_AW+1)'(wr_a);
            ra    <= flush ? '0 : ra + (FIFO_AW+1)'(pop);
            wb    <= flush ? '0 : wb + (FIFO_AW+1)'(wr_b);
            rb    <= flush ? '0 : rb + (FIFO_AW+1)'(pop);
            if (flush) vld <= 1'b0;
            else if (pop || pad) begin
                vld <= 1'b1;
                da  <= pad ? '0 : mem_a[ra[FIFO_AW-1:0]];
                db  <= pad ? '0 : mem_b[rb[FIFO_AW-1:0]];
            end else if (hs) vld <= 1'b0;
            if (hs) beat <= last ? 16'd0 : beat + 16'd1;
            if (hs && last) frame_cnt <= frame_cnt + 16'd1;
            if (start || (state == RUN && hs && last))
                len <= frame_len == 16'd0 ? 16'd1 : frame_len;
            if (start) begin
                frame_cnt <= 16'd0;
                ovf_a     <= 1'b0;
                ovf_b     <= 1'b0;
            end else begin
                if (active && a_vld && full_a && !pop) ovf_a <= 1'b1;
                if (active && b_vld && full_b && !pop) ovf_b <= 1'b1;
            end
        end
    end

    assign m00_axis_tdata  = da;
    assign m01_axis_tdata  = db;
    assign m00_axis_tvalid = vld;
    assign m01_axis_tvalid = vld;
    assign m00_axis_tlast  = last;
    assign m01_axis_tlast  = last;
    assign busy            = active;
endmodule

// File: tb/tb_cmlk_dual_axis_frame_src.sv
// tb_cmlk_dual_axis_frame_src: directed scenarios for the dual-stream frame source.
// Padding expectations follow CMLK_TX_PAD_EN.
module tb_cmlk_dual_axis_frame_src;
    logic        clk = 1'b0;
    logic        rst, enable;
    logic [15:0] frame_len;
    logic [7:0]  a_data, b_data;
    logic        a_vld, b_vld;
    logic [7:0]  m00_axis_tdata, m01_axis_tdata;
    logic        m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
    logic        m01_axis_tvalid, m01_axis_tlast, m01_axis_tready;
    logic        ovf_a, ovf_b, busy;
    logic [15:0] frame_cnt;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    cmlk_dual_axis_frame_src #(.DATA_W(8), .FIFO_AW(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_len(frame_len),
        .a_data(a_data), .a_vld(a_vld), .b_data(b_data), .b_vld(b_vld),
        .m00_axis_tdata(m00_axis_tdata), .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tlast(m00_axis_tlast), .m00_axis_tready(m00_axis_tready),
        .m01_axis_tdata(m01_axis_tdata), .m01_axis_tvalid(m01_axis_tvalid),
        .m01_axis_tlast(m01_axis_tlast), .m01_axis_tready(m01_axis_tready),
        .ovf_a(ovf_a), .ovf_b(ovf_b), .frame_cnt(frame_cnt), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [7:0] a, input logic [7:0] b);
        a_vld  = v;
        b_vld  = v;
        a_data = a;
        b_data = b;
    endtask

    task automatic wait_idle;
        enable = 1'b0;
        for (int k = 0; k < 20 && busy; k++) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; frame_len = 16'd0;
        push(1'b0, 8'h00, 8'h00);
        m00_axis_tready = 1'b0; m01_axis_tready = 1'b0;
        tick();
        total++;
        if ({m00_axis_tvalid, m01_axis_tvalid, m00_axis_tlast, m01_axis_tlast, busy, ovf_a, ovf_b} !== 7'b0)
            $display("FAIL reset_flags got %b want 0", {m00_axis_tvalid, m01_axis_tvalid, m00_axis_tlast, m01_axis_tlast, busy, ovf_a, ovf_b});
        else passed++;
        total++;
        if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        enable = 1'b1; frame_len = 16'd4;
        m00_axis_tready = 1'b1; m01_axis_tready = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            logic lst;
            push(1'b1, 8'h10 + 8'(i), 8'h20 + 8'(i));
            tick();
            lst = ((i - 1) % 4) == 3;
            total++;
            if (i == 0) begin
                if (m00_axis_tvalid !== 1'b0) $display("FAIL basic_latency tvalid got %b want 0", m00_axis_tvalid);
                else passed++;
            end else if ({m00_axis_tvalid, m01_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m00_axis_tlast, m01_axis_tlast}
                         !== {1'b1, 1'b1, 8'h10 + 8'(i - 1), 8'h20 + 8'(i - 1), lst, lst})
                $display("FAIL basic_beat%0d got v=%b%b a=%h b=%h l=%b%b want a=%h b=%h l=%b", i, m00_axis_tvalid, m01_axis_tvalid,
                         m00_axis_tdata, m01_axis_tdata, m00_axis_tlast, m01_axis_tlast, 8'h10 + 8'(i - 1), 8'h20 + 8'(i - 1), lst);
            else passed++;
            if (i == 5) begin
                total++;
                if (frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt1 got %0d want 1", frame_cnt);
                else passed++;
            end
        end
        push(1'b0, 8'h00, 8'h00);
        tick();
        total++;
        if ({m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m00_axis_tlast, m01_axis_tlast} !== {1'b1, 8'h17, 8'h27, 1'b1, 1'b1})
            $display("FAIL basic_beat8 got v=%b a=%h b=%h l=%b%b want 1 17 27 11", m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata,
                     m00_axis_tlast, m01_axis_tlast);
        else passed++;
        tick();
        total++;
        if (m00_axis_tvalid !== 1'b0) $display("FAIL basic_empty tvalid got %b want 0", m00_axis_tvalid);
        else passed++;
        total++;
        if (frame_cnt !== 16'd2) $display("FAIL basic_frame_cnt2 got %0d want 2", frame_cnt);
        else passed++;
        wait_idle();
        total++;
        if (busy !== 1'b0) $display("FAIL basic_idle busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_stall;
        int idx = 0;
        int cyc = 0;
        enable = 1'b1; frame_len = 16'd3;
        m00_axis_tready = 1'b1;
        tick();
        while (idx < 6 && cyc < 40) begin
            if (cyc < 6) push(1'b1, 8'h30 + 8'(cyc), 8'h40 + 8'(cyc));
            else push(1'b0, 8'h00, 8'h00);
            m01_axis_tready = (cyc % 2) == 0;
            total++;
            if (m00_axis_tvalid !== m01_axis_tvalid) $display("FAIL stall_valid_pair got %b %b want equal", m00_axis_tvalid, m01_axis_tvalid);
            else passed++;
            if (m00_axis_tvalid) begin
                total++;
                if ({m00_axis_tdata, m01_axis_tdata, m00_axis_tlast, m01_axis_tlast} !== {8'h30 + 8'(idx), 8'h40 + 8'(idx), (idx % 3) == 2, (idx % 3) == 2})
                    $display("FAIL stall_beat%0d got a=%h b=%h l=%b%b want a=%h b=%h l=%b", idx, m00_axis_tdata, m01_axis_tdata,
                             m00_axis_tlast, m01_axis_tlast, 8'h30 + 8'(idx), 8'h40 + 8'(idx), (idx % 3) == 2);
                else passed++;
            end
            if (m00_axis_tvalid && m01_axis_tready) idx++;
            tick();
            cyc++;
        end
        push(1'b0, 8'h00, 8'h00);
        m01_axis_tready = 1'b1;
        total++;
        if (idx !== 6) $display("FAIL stall_beats got %0d want 6", idx);
        else passed++;
        total++;
        if (frame_cnt !== 16'd2) $display("FAIL stall_frame_cnt got %0d want 2", frame_cnt);
        else passed++;
        wait_idle();
    endtask

    task automatic test_overflow;
        enable = 1'b1; frame_len = 16'd17;
        m00_axis_tready = 1'b0; m01_axis_tready = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            push(1'b1, 8'h50 + 8'(i), 8'hA0 + 8'(i));
            tick();
            if (i == 16) begin
                total++;
                if ({ovf_a, ovf_b} !== 2'b00) $display("FAIL ovf_at_full got %b%b want 00", ovf_a, ovf_b);
                else passed++;
            end
        end
        push(1'b0, 8'h00, 8'h00);
        tick();
        total++;
        if ({ovf_a, ovf_b} !== 2'b11) $display("FAIL ovf_sticky got %b%b want 11", ovf_a, ovf_b);
        else passed++;
        m00_axis_tready = 1'b1; m01_axis_tready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            total++;
            if ({m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m00_axis_tlast} !== {1'b1, 8'h50 + 8'(k), 8'hA0 + 8'(k), k == 16})
                $display("FAIL ovf_beat%0d got v=%b a=%h b=%h l=%b want a=%h b=%h", k, m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata,
                         m00_axis_tlast, 8'h50 + 8'(k), 8'hA0 + 8'(k));
            else passed++;
            tick();
        end
        total++;
        if (m00_axis_tvalid !== 1'b0) $display("FAIL ovf_extra tvalid got %b want 0", m00_axis_tvalid);
        else passed++;
        total++;
        if (frame_cnt !== 16'd1) $display("FAIL ovf_frame_cnt got %0d want 1", frame_cnt);
        else passed++;
        wait_idle();
    endtask

    task automatic test_drain;
        enable = 1'b1; frame_len = 16'd5;
        tick();
        total++;
        if ({ovf_a, ovf_b, frame_cnt} !== 18'd0) $display("FAIL start_clear got ovf=%b%b cnt=%0d want 0", ovf_a, ovf_b, frame_cnt);
        else passed++;
        for (int c = 0; c < 9; c++) begin
            push(1'b1, 8'h60 + 8'(c), 8'h70 + 8'(c));
            if (c == 3) enable = 1'b0;
            tick();
            if (c >= 1 && c <= 5) begin
                total++;
                if ({m00_axis_tvalid, m01_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m00_axis_tlast, m01_axis_tlast, busy}
                    !== {1'b1, 1'b1, 8'h60 + 8'(c - 1), 8'h70 + 8'(c - 1), c == 5, c == 5, 1'b1})
                    $display("FAIL drain_beat%0d got v=%b a=%h b=%h l=%b busy=%b want a=%h b=%h", c, m00_axis_tvalid, m00_axis_tdata,
                             m01_axis_tdata, m00_axis_tlast, busy, 8'h60 + 8'(c - 1), 8'h70 + 8'(c - 1));
                else passed++;
            end else if (c >= 6) begin
                total++;
                if ({m00_axis_tvalid, busy} !== 2'b00) $display("FAIL drain_idle_c%0d got v=%b busy=%b want 00", c, m00_axis_tvalid, busy);
                else passed++;
            end
        end
        push(1'b0, 8'h00, 8'h00);
        total++;
        if (frame_cnt !== 16'd1) $display("FAIL drain_frame_cnt got %0d want 1", frame_cnt);
        else passed++;
    endtask

    task automatic test_pad;
        int npad = 0;
        enable = 1'b1; frame_len = 16'd5;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c < 2) push(1'b1, 8'hE0 + 8'(c), 8'hF0 + 8'(c));
            else push(1'b0, 8'h00, 8'h00);
            if (c == 3) enable = 1'b0;
            tick();
            if (c == 1 || c == 2) begin
                total++;
                if ({m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m00_axis_tlast} !== {1'b1, 8'hE0 + 8'(c - 1), 8'hF0 + 8'(c - 1), 1'b0})
                    $display("FAIL pad_real%0d got v=%b a=%h b=%h l=%b", c, m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m00_axis_tlast);
                else passed++;
            end else if (c == 3) begin
                total++;
                if (m00_axis_tvalid !== 1'b0) $display("FAIL pad_gap tvalid got %b want 0", m00_axis_tvalid);
                else passed++;
            end
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m00_axis_tvalid) begin
                total++;
                if ({m00_axis_tdata, m01_axis_tdata, m00_axis_tlast, m01_axis_tlast} !== {8'h00, 8'h00, npad == 2, npad == 2})
                    $display("FAIL pad_beat%0d got a=%h b=%h l=%b%b want 00 00 %b", npad, m00_axis_tdata, m01_axis_tdata,
                             m00_axis_tlast, m01_axis_tlast, npad == 2);
                else passed++;
                npad++;
            end
            if (!busy) break;
        end
`ifdef CMLK_TX_PAD_EN
        total++;
        if (npad !== 3) $display("FAIL pad_count got %0d want 3", npad);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL pad_busy got %b want 0", busy);
        else passed++;
        total++;
        if (frame_cnt !== 16'd1) $display("FAIL pad_frame_cnt got %0d want 1", frame_cnt);
        else passed++;
`else
        total++;
        if (npad !== 0) $display("FAIL nopad_count got %0d want 0", npad);
        else passed++;
        total++;
        if (busy !== 1'b1) $display("FAIL nopad_busy got %b want 1", busy);
        else passed++;
        total++;
        if (frame_cnt !== 16'd0) $display("FAIL nopad_frame_cnt got %0d want 0", frame_cnt);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid;
        m00_axis_tready = 1'b1; m01_axis_tready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        enable = 1'b1; frame_len = 16'd6;
        tick();
        for (int c = 0; c < 3; c++) begin
            push(1'b1, 8'h90 + 8'(c), 8'hB0 + 8'(c));
            tick();
        end
        total++;
        if ({m00_axis_tvalid, m00_axis_tdata} !== {1'b1, 8'h91}) $display("FAIL rstmid_pre got v=%b a=%h want 1 91", m00_axis_tvalid, m00_axis_tdata);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({m00_axis_tvalid, m01_axis_tvalid, m00_axis_tlast, m01_axis_tlast, busy} !== 5'b0)
            $display("FAIL rstmid_async got %b want 0", {m00_axis_tvalid, m01_axis_tvalid, m00_axis_tlast, m01_axis_tlast, busy});
        else passed++;
        total++;
        if (frame_cnt !== 16'd0) $display("FAIL rstmid_frame_cnt got %0d want 0", frame_cnt);
        else passed++;
        push(1'b0, 8'h00, 8'h00);
        tick();
        rst = 1'b0; frame_len = 16'd0; enable = 1'b1;
        tick();
        push(1'b1, 8'hC0, 8'hD0);
        tick();
        total++;
        if (m00_axis_tvalid !== 1'b0) $display("FAIL restart_stale tvalid got %b want 0", m00_axis_tvalid);
        else passed++;
        push(1'b1, 8'hC1, 8'hD1);
        tick();
        total++;
        if ({m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m00_axis_tlast} !== {1'b1, 8'hC0, 8'hD0, 1'b1})
            $display("FAIL restart_beat0 got v=%b a=%h b=%h l=%b want 1 c0 d0 1", m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m00_axis_tlast);
        else passed++;
        push(1'b0, 8'h00, 8'h00);
        tick();
        total++;
        if ({m00_axis_tvalid, m00_axis_tdata, m01_axis_tdata, m01_axis_tlast, frame_cnt} !== {1'b1, 8'hC1, 8'hD1, 1'b1, 16'd1})
            $display("FAIL restart_beat1 got v=%b a=%h b=%h l=%b cnt=%0d want 1 c1 d1 1 1", m00_axis_tvalid, m00_axis_tdata,
                     m01_axis_tdata, m01_axis_tlast, frame_cnt);
        else passed++;
        tick();
        total++;
        if ({m00_axis_tvalid, frame_cnt} !== {1'b0, 16'd2}) $display("FAIL restart_end got v=%b cnt=%0d want 0 2", m00_axis_tvalid, frame_cnt);
        else passed++;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_drain();
        test_pad();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
